axi_burst_splitter: RTL

Converts full AXI4 bursts from the core-side interconnect into a sequence of single-beat AXI transactions for the on-chip memory wrapper, which handles only single beats and ignores len/last/id. Sits directly upstream of the memory wrapper. It provides burst address generation (FIXED/INCR/WRAP), ID echo, RLAST generation and WLAST checking. The read and write paths are independent engines; the downstream wrapper arbitrates between them.

---
 rtl/axi_burst_splitter.sv | 227 ++++++++++++++++++++++
 1 files changed

// File: rtl/axi_burst_splitter.sv
// axi_burst_splitter: breaks AXI4 bursts into single-beat transactions for a
// memory wrapper that understands only one beat at a time. Independent write
// and read engines; IDs, RLAST and the write response are regenerated here.
module axi_burst_splitter #(
  parameter int ID_WIDTH = 4,
  parameter int AW       = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [ID_WIDTH-1:0] i_awid,
  input  logic [AW-1:0]       i_awaddr,
  input  logic [7:0]          i_awlen,
  input  logic [2:0]          i_awsize,
  input  logic [1:0]          i_awburst,
  input  logic                i_awvalid,
  output logic                o_awready,
  input  logic [63:0]         i_wdata,
  input  logic [7:0]          i_wstrb,
  input  logic                i_wlast,
  input  logic                i_wvalid,
  output logic                o_wready,
  output logic [ID_WIDTH-1:0] o_bid,
  output logic [1:0]          o_bresp,
  output logic                o_bvalid,
  input  logic                i_bready,
  input  logic [ID_WIDTH-1:0] i_arid,
  input  logic [AW-1:0]       i_araddr,
  input  logic [7:0]          i_arlen,
  input  logic [2:0]          i_arsize,
  input  logic [1:0]          i_arburst,
  input  logic                i_arvalid,
  output logic                o_arready,
  output logic [ID_WIDTH-1:0] o_rid,
  output logic [63:0]         o_rdata,
  output logic [1:0]          o_rresp,
  output logic                o_rlast,
  output logic                o_rvalid,
  input  logic                i_rready,
  output logic [AW-1:0]       o_m_awaddr,
  output logic                o_m_awvalid,
  input  logic                i_m_awready,
  output logic [63:0]         o_m_wdata,
  output logic [7:0]          o_m_wstrb,
  output logic                o_m_wvalid,
  input  logic                i_m_wready,
  input  logic                i_m_bvalid,
  output logic                o_m_bready,
  output logic [AW-1:0]       o_m_araddr,
  output logic                o_m_arvalid,
  input  logic                i_m_arready,
  input  logic [63:0]         i_m_rdata,
  input  logic                i_m_rvalid,
  output logic                o_m_rready
);

  typedef enum logic [1:0] {W_IDLE, W_BEAT, W_WAIT, W_RESP} w_state_t;
  typedef enum logic [1:0] {R_IDLE, R_ADDR, R_DATA} r_state_t;

  // Next beat address; beats wider than the 64-bit bus are clamped to 8 bytes.
  function automatic logic [AW-1:0] f_next_addr(input logic [AW-1:0] a,
                                                input logic [7:0] len,
                                                input logic [2:0] size,
                                                input logic [1:0] burst);
    logic [1:0]    sz;
    logic [AW-1:0] step, mask;
    sz   = (size > 3'd3) ? 2'd3 : size[1:0];
    step = AW'(1) << sz;
    mask = ((AW'(len) + AW'(1)) << sz) - AW'(1);
    case (burst)
      2'b00:   f_next_addr = a;
      2'b10:   f_next_addr = (a & ~mask) | ((a + step) & mask);
      default: f_next_addr = a + step;
    endcase
  endfunction

  // ---------------- write engine ----------------
  w_state_t            r_wst, w_wst_nxt;
  logic [ID_WIDTH-1:0] r_wid;
  logic [AW-1:0]       r_waddr;
  logic [7:0]          r_wlen, r_wcnt;
  logic [2:0]          r_wsize;
  logic [1:0]          r_wburst;
  logic                r_werr, r_aw_done, r_w_done;
  logic                w_aw_hs, w_maw_hs, w_w_hs, w_wlast;

  assign w_aw_hs  = (r_wst == W_IDLE) && i_awvalid;
  assign w_maw_hs = (r_wst == W_BEAT) && !r_aw_done && i_m_awready;
  assign w_w_hs   = (r_wst == W_BEAT) && !r_w_done && i_wvalid && i_m_wready;
  assign w_wlast  = (r_wcnt == r_wlen);
  assign o_bid      = r_wid;
  assign o_m_awaddr = r_waddr;

  // Write state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_wst <= W_IDLE;
    else        r_wst <= w_wst_nxt;
  end

  // Write next-state and channel outputs; the current beat's W path is
  // closed once its handshake has happened.
  always_comb begin
    w_wst_nxt   = r_wst;
    o_awready   = 1'b0;
    o_wready    = 1'b0;
    o_bvalid    = 1'b0;
    o_bresp     = 2'b00;
    o_m_awvalid = 1'b0;
    o_m_wvalid  = 1'b0;
    o_m_wdata   = '0;
    o_m_wstrb   = '0;
    o_m_bready  = 1'b0;
    case (r_wst)
      W_IDLE: begin
        o_awready = rst_n;
        if (i_awvalid) w_wst_nxt = W_BEAT;
      end
      W_BEAT: begin
        o_m_awvalid = !r_aw_done;
        if (!r_w_done) begin
          o_m_wvalid = i_wvalid;
          o_m_wdata  = i_wdata;
          o_m_wstrb  = i_wstrb;
          o_wready   = i_m_wready;
        end
        if ((r_aw_done || w_maw_hs) && (r_w_done || w_w_hs)) w_wst_nxt = W_WAIT;
      end
      W_WAIT: begin
        o_m_bready = 1'b1;
        if (i_m_bvalid) w_wst_nxt = w_wlast ? W_RESP : W_BEAT;
      end
      default: begin
        o_bvalid = 1'b1;
        o_bresp  = r_werr ? 2'b10 : 2'b00;
        if (i_bready) w_wst_nxt = W_IDLE;
      end
    endcase
  end

  // Write burst context: latch on AW, track per-beat progress, check WLAST.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wid <= '0; r_waddr <= '0; r_wlen <= '0; r_wsize <= '0; r_wburst <= '0;
      r_wcnt <= '0; r_werr <= 1'b0; r_aw_done <= 1'b0; r_w_done <= 1'b0;
    end else if (w_aw_hs) begin
      r_wid <= i_awid; r_waddr <= i_awaddr; r_wlen <= i_awlen;
      r_wsize <= i_awsize; r_wburst <= i_awburst;
      r_wcnt <= '0; r_werr <= 1'b0; r_aw_done <= 1'b0; r_w_done <= 1'b0;
    end else begin
      if (w_maw_hs) r_aw_done <= 1'b1;
      if (w_w_hs) begin
        r_w_done <= 1'b1;
        if (i_wlast != w_wlast) r_werr <= 1'b1;
      end
      if (r_wst == W_WAIT && i_m_bvalid && !w_wlast) begin
        r_waddr   <= f_next_addr(r_waddr, r_wlen, r_wsize, r_wburst);
        r_wcnt    <= r_wcnt + 8'd1;
        r_aw_done <= 1'b0;
        r_w_done  <= 1'b0;
      end
    end
  end

  // ---------------- read engine ----------------
  r_state_t            r_rst, w_rst_nxt;
  logic [ID_WIDTH-1:0] r_rid;
  logic [AW-1:0]       r_raddr;
  logic [7:0]          r_rlen, r_rcnt;
  logic [2:0]          r_rsize;
  logic [1:0]          r_rburst;
  logic                w_ar_hs, w_r_hs, w_rlast;

  assign w_ar_hs    = (r_rst == R_IDLE) && i_arvalid;
  assign w_r_hs     = (r_rst == R_DATA) && i_m_rvalid && i_rready;
  assign w_rlast    = (r_rcnt == r_rlen);
  assign o_rid      = r_rid;
  assign o_rresp    = 2'b00;
  assign o_m_araddr = r_raddr;

  // Read state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_rst <= R_IDLE;
    else        r_rst <= w_rst_nxt;
  end

  // Read next-state and outputs; R data passes straight through in R_DATA.
  always_comb begin
    w_rst_nxt   = r_rst;
    o_arready   = 1'b0;
    o_m_arvalid = 1'b0;
    o_rvalid    = 1'b0;
    o_rdata     = '0;
    o_rlast     = 1'b0;
    o_m_rready  = 1'b0;
    case (r_rst)
      R_IDLE: begin
        o_arready = rst_n;
        if (i_arvalid) w_rst_nxt = R_ADDR;
      end
      R_ADDR: begin
        o_m_arvalid = 1'b1;
        if (i_m_arready) w_rst_nxt = R_DATA;
      end
      default: begin
        o_rvalid   = i_m_rvalid;
        o_rdata    = i_m_rdata;
        o_rlast    = w_rlast;
        o_m_rready = i_rready;
        if (w_r_hs) w_rst_nxt = w_rlast ? R_IDLE : R_ADDR;
      end
    endcase
  end

  // Read burst context: latch on AR, advance after each delivered beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rid <= '0; r_raddr <= '0; r_rlen <= '0; r_rsize <= '0;
      r_rburst <= '0; r_rcnt <= '0;
    end else if (w_ar_hs) begin
      r_rid <= i_arid; r_raddr <= i_araddr; r_rlen <= i_arlen;
      r_rsize <= i_arsize; r_rburst <= i_arburst; r_rcnt <= '0;
    end else if (w_r_hs && !w_rlast) begin
      r_raddr <= f_next_addr(r_raddr, r_rlen, r_rsize, r_rburst);
      r_rcnt  <= r_rcnt + 8'd1;
    end
  end

endmodule
